// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Parametrised register file for the pipelined KGP-RISC core.
//            Synchronous-read array with NUM_RD independent read ports and a
//            per-register busy bit (pending-write scoreboard). The bit is set
//            at issue and cleared at write-back. One register (ZERO_REG) is
//            hardwired to zero and is never marked busy.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width, depth = 2**ADDR_W
//   NUM_RD    number of read ports (1..4)
//   ZERO_REG  index of the hardwired zero register
// Ports
//   clk       system clock, all state updates on rising edge
//   rst_n     synchronous active-low reset
//   rd_addr   NUM_RD packed read addresses (port i at [i*ADDR_W +: ADDR_W])
//   rd_data   NUM_RD packed registered read data (same packing)
//   rd_busy   registered busy bit of each addressed register
//   wr_en     write-back strobe
//   wr_addr   write-back address
//   wr_data   write-back data
//   iss_en    issue strobe, marks iss_addr pending
//   iss_addr  destination register of the issuing instruction
//   busy_any  registered OR of the next-state busy vector
// Build option
//   REGFILE_BYPASS_EN  when defined, a read that hits the same-cycle
//                      write-back registers wr_data and the post-update busy
//                      bit (write-first). When undefined, reads are
//                      read-first.
// ============================================================================
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       busy_any
);

    localparam int                c_DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;
    logic [c_DEPTH-1:0] w_busy_nxt;
    logic               r_busy_any;
    logic               w_wr_hit;
    logic               w_iss_hit;

    // Traffic aimed at the zero register is dropped here so that neither the
    // array nor the scoreboard ever sees it.
    assign w_wr_hit  = wr_en  && (wr_addr  != c_ZERO_ADDR);
    assign w_iss_hit = iss_en && (iss_addr != c_ZERO_ADDR);

    // Issue is applied after write-back so a same-cycle issue to the register
    // being written leaves it busy: the new producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_hit) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_iss_hit) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end
        w_busy_nxt[c_ZERO_ADDR] = 1'b0;
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < c_DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr_hit) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Scoreboard
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_any <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_any <= |w_busy_nxt;
        end
    end

    assign busy_any = r_busy_any;

    // Read ports
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] r_data;
            logic              r_bsy;

            assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data <= '0;
                    r_bsy  <= 1'b0;
                end else if (w_addr == c_ZERO_ADDR) begin
                    r_data <= '0;
                    r_bsy  <= 1'b0;
                end else begin
`ifdef REGFILE_BYPASS_EN
                    if (w_wr_hit && (w_addr == wr_addr)) begin
                        r_data <= wr_data;
                    end else begin
                        r_data <= r_mem[w_addr];
                    end
                    // Post-update bit: cleared by the write-back unless a
                    // same-cycle issue re-marks it.
                    r_bsy <= w_busy_nxt[w_addr];
`else
                    r_data <= r_mem[w_addr];
                    r_bsy  <= r_busy[w_addr];
`endif
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = r_data;
            assign rd_busy[gi]                  = r_bsy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Directed-vector bench for regfile_sb (default parameters, two
//            read ports). Expectations depend on REGFILE_BYPASS_EN where the
//            two builds differ.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     busy_any;

    int n_vec;
    int n_err;

    regfile_sb #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (31)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_any (busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit so outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;

        // Reset held for two cycles, then sweep addresses 0..30
        tick();
        tick();
        rst_n = 1'b1;
        for (int a = 0; a < 31; a++) begin
            set_rd(ADDR_W'(a), ADDR_W'(30 - a));
            tick();
            chk("rst_data0", rd_data[31:0], 32'h0);
            chk("rst_data1", rd_data[63:32], 32'h0);
            chk("rst_busy", {30'h0, rd_busy}, 32'h0);
            chk("rst_any", {31'h0, busy_any}, 32'h0);
        end

        // Basic write then read on both ports
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        set_rd(5'd5, 5'd5);
        tick();
        chk("basic_p0", rd_data[31:0], 32'hDEADBEEF);
        chk("basic_p1", rd_data[63:32], 32'hDEADBEEF);

        // Zero register: write and issue are ignored
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h12345678;
        iss_en = 1'b1; iss_addr = 5'd31;
        set_rd(5'd31, 5'd31);
        tick();
        chk("zero_same_cyc", rd_data[31:0], 32'h0);
        idle();
        tick();
        chk("zero_data", rd_data[31:0], 32'h0);
        chk("zero_busy", {30'h0, rd_busy}, 32'h0);
        chk("zero_any", {31'h0, busy_any}, 32'h0);

        // Same-cycle write and read
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
        tick();
        wr_data = 32'h22;
        set_rd(5'd7, 5'd5);
        tick();
        chk("wr_rd_same", rd_data[31:0], c_BYP ? 32'h22 : 32'h11);
        chk("wr_rd_other", rd_data[63:32], 32'hDEADBEEF);
        idle();
        tick();
        chk("wr_rd_next", rd_data[31:0], 32'h22);

        // Scoreboard: issue, observe busy, write back
        iss_en = 1'b1; iss_addr = 5'd3;
        set_rd(5'd3, 5'd7);
        tick();
        chk("iss_any_early", {31'h0, busy_any}, 32'h1);
        idle();
        tick();
        chk("iss_busy", {31'h0, rd_busy[0]}, 32'h1);
        chk("iss_busy_other", {31'h0, rd_busy[1]}, 32'h0);
        chk("iss_any", {31'h0, busy_any}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
        tick();
        chk("wb_busy_same", {31'h0, rd_busy[0]}, c_BYP ? 32'h0 : 32'h1);
        chk("wb_data_same", rd_data[31:0], c_BYP ? 32'hA5 : 32'h0);
        chk("wb_any", {31'h0, busy_any}, 32'h0);
        idle();
        tick();
        chk("wb_busy", {31'h0, rd_busy[0]}, 32'h0);
        chk("wb_data", rd_data[31:0], 32'hA5);

        // Simultaneous issue and write-back to r3: busy stays set
        iss_en = 1'b1; iss_addr = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h5A;
        tick();
        chk("both_busy_same", {31'h0, rd_busy[0]}, c_BYP ? 32'h1 : 32'h0);
        idle();
        tick();
        chk("both_busy", {31'h0, rd_busy[0]}, 32'h1);
        chk("both_any", {31'h0, busy_any}, 32'h1);
        chk("both_data", rd_data[31:0], 32'h5A);

        // Repeated issue, single write-back clears
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
        tick();
        idle();
        tick();
        chk("reiss_busy", {31'h0, rd_busy[0]}, 32'h0);
        chk("reiss_any", {31'h0, busy_any}, 32'h0);

        // Two pending registers: busy_any holds until both retire
        iss_en = 1'b1; iss_addr = 5'd10;
        tick();
        iss_addr = 5'd11;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h1;
        set_rd(5'd10, 5'd11);
        tick();
        chk("two_any_half", {31'h0, busy_any}, 32'h1);
        idle();
        tick();
        chk("two_busy", {30'h0, rd_busy}, 32'h2);
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h2;
        tick();
        idle();
        chk("two_any_done", {31'h0, busy_any}, 32'h0);

        // Reset mid-operation discards write and issue of that cycle
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFF;
        set_rd(5'd5, 5'd3);
        rst_n = 1'b0;
        tick();
        chk("mrst_data0", rd_data[31:0], 32'h0);
        chk("mrst_data1", rd_data[63:32], 32'h0);
        chk("mrst_any", {31'h0, busy_any}, 32'h0);
        rst_n = 1'b1;
        idle();
        set_rd(5'd4, 5'd9);
        tick();
        chk("mrst_r4", rd_data[31:0], 32'h0);
        chk("mrst_r9_busy", {31'h0, rd_busy[1]}, 32'h0);
        chk("mrst_any2", {31'h0, busy_any}, 32'h0);
        set_rd(5'd5, 5'd7);
        tick();
        chk("mrst_r5", rd_data[31:0], 32'h0);
        chk("mrst_r7", rd_data[63:32], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
